// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Game-wide constants shared with the rendering path.
// Revision : 1.0
// ============================================================================
package game_pkg;

  // Signed width of the player's world x/y position
  localparam int POS_WIDTH = 11;

endpackage
`default_nettype wire

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : World-map SRAM geometry, border colour, fetch classification
//            and the RGB565 -> RGB888 expansion used by the colour path.
// Revision : 1.0
// ============================================================================
package sram_pkg;

  localparam int          MAP_LOG2_W   = 10;
  localparam int          MAP_LOG2_H   = 10;
  localparam int          ADDR_WIDTH   = 20;
  localparam int          DATA_WIDTH   = 16;
  localparam logic [23:0] BORDER_COLOR = 24'h202020;

  // How a pixel slot was resolved at read-issue time
  typedef enum logic [1:0] {
    FETCH_READ = 2'd0,
    FETCH_OOB  = 2'd1,
    FETCH_MISS = 2'd2
  } fetch_kind_t;

  // Replicate the top bits of each channel into the new low bits so that
  // full-scale 5/6-bit values map to full-scale 8-bit values.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] px);
    return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_coord_xlate.sv
`default_nettype none
// ============================================================================
// Module   : map_coord_xlate
// Brief    : Combinational screen -> world translation centred on the camera,
//            with out-of-map detection. Only the in-map index bits leave.
// Revision : 1.0
// ============================================================================
module map_coord_xlate #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int H_WIDTH    = 10,
  parameter int V_WIDTH    = 10,
  parameter int POS_WIDTH  = 11,
  parameter int MAP_LOG2_W = 10,
  parameter int MAP_LOG2_H = 10
) (
  input  logic signed [POS_WIDTH-1:0]  cam_x_i,
  input  logic signed [POS_WIDTH-1:0]  cam_y_i,
  input  logic        [H_WIDTH-1:0]    h_i,
  input  logic        [V_WIDTH-1:0]    v_i,
  output logic        [MAP_LOG2_W-1:0] map_x_o,
  output logic        [MAP_LOG2_H-1:0] map_y_o,
  output logic                         oob_o
);

  // Two guard bits cover camera range plus screen offset without overflow
  localparam int WW = POS_WIDTH + 2;

  localparam logic signed [WW-1:0] HALF_W = WW'(SCREEN_W / 2);
  localparam logic signed [WW-1:0] HALF_H = WW'(SCREEN_H / 2);
  localparam logic signed [WW-1:0] MAP_W  = WW'(1 << MAP_LOG2_W);
  localparam logic signed [WW-1:0] MAP_H  = WW'(1 << MAP_LOG2_H);

  logic signed [WW-1:0] wx;
  logic signed [WW-1:0] wy;

  // World coordinate = camera centre - half screen + screen coordinate
  always_comb begin
    wx      = {{(WW-POS_WIDTH){cam_x_i[POS_WIDTH-1]}}, cam_x_i} - HALF_W + WW'(h_i);
    wy      = {{(WW-POS_WIDTH){cam_y_i[POS_WIDTH-1]}}, cam_y_i} - HALF_H + WW'(v_i);
    oob_o   = wx[WW-1] || (wx >= MAP_W) || wy[WW-1] || (wy >= MAP_H);
    map_x_o = wx[MAP_LOG2_W-1:0];
    map_y_o = wy[MAP_LOG2_H-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/map_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : map_pixel_fetch
// Brief    : Three-stage pixel fetch: camera-relative translate, SRAM read
//            issue, colour expansion with border / last-good substitution and
//            a per-frame count of reads lost to the frame encoder.
// Revision : 1.0
// ============================================================================
module map_pixel_fetch
  import sram_pkg::fetch_kind_t;
  import sram_pkg::FETCH_READ;
  import sram_pkg::FETCH_OOB;
  import sram_pkg::FETCH_MISS;
  import sram_pkg::rgb565_to_rgb888;
#(
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          H_WIDTH      = 10,
  parameter int          V_WIDTH      = 10,
  parameter int          MAP_LOG2_W   = sram_pkg::MAP_LOG2_W,
  parameter int          MAP_LOG2_H   = sram_pkg::MAP_LOG2_H,
  parameter int          POS_WIDTH    = game_pkg::POS_WIDTH,
  parameter int          ADDR_WIDTH   = sram_pkg::ADDR_WIDTH,
  parameter int          DATA_WIDTH   = sram_pkg::DATA_WIDTH,
  parameter logic [23:0] BORDER_COLOR = sram_pkg::BORDER_COLOR,
  parameter int          MISS_WIDTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic        [H_WIDTH-1:0]   i_VGA_H,
  input  logic        [V_WIDTH-1:0]   i_VGA_V,
  input  logic                        i_req_valid,
  input  logic signed [POS_WIDTH-1:0] i_player_x,
  input  logic signed [POS_WIDTH-1:0] i_player_y,
  input  logic                        i_sram_busy,
  output logic        [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                        o_sram_rd,
  input  logic        [DATA_WIDTH-1:0] i_sram_data,
  output logic                        o_pixel_valid,
  output logic        [23:0]          o_pixel_color,
  output logic        [H_WIDTH-1:0]   o_pixel_H,
  output logic        [V_WIDTH-1:0]   o_pixel_V,
  output logic        [MISS_WIDTH-1:0] o_frame_miss_cnt
);

  // ---------------- camera ----------------
  logic                        frame_start;
  logic signed [POS_WIDTH-1:0] cam_x_q, cam_x_d;
  logic signed [POS_WIDTH-1:0] cam_y_q, cam_y_d;

  // ---------------- stage 1 (translated slot) ----------------
  logic                  s1_valid_q, s1_oob_q, s1_busy_q;
  logic [MAP_LOG2_W-1:0] s1_mx_q, s1_mx_d;
  logic [MAP_LOG2_H-1:0] s1_my_q, s1_my_d;
  logic                  s1_oob_d;
  logic [H_WIDTH-1:0]    s1_h_q;
  logic [V_WIDTH-1:0]    s1_v_q;

  // ---------------- stage 2 (read issued) ----------------
  logic                  s2_valid_q;
  fetch_kind_t           s2_kind_q, s2_kind_d;
  logic [H_WIDTH-1:0]    s2_h_q;
  logic [V_WIDTH-1:0]    s2_v_q;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // ---------------- stage 3 (pixel out) ----------------
  logic                  pix_valid_q;
  logic [23:0]           pix_color_q, pix_color_d;
  logic [H_WIDTH-1:0]    pix_h_q, pix_h_d;
  logic [V_WIDTH-1:0]    pix_v_q, pix_v_d;
  logic [23:0]           last_color_q, last_color_d;
  logic [MISS_WIDTH-1:0] miss_acc_q, miss_acc_d;
  logic [MISS_WIDTH-1:0] frame_miss_q, frame_miss_d;
  logic                  miss_now;
  logic [23:0]           sram_rgb;

  assign frame_start = i_req_valid && (i_VGA_H == '0) && (i_VGA_V == '0);

  // Pixel (0,0) sees the freshly sampled player position, hence the bypass
  always_comb begin
    cam_x_d = cam_x_q;
    cam_y_d = cam_y_q;
    if (frame_start) begin
      cam_x_d = i_player_x;
      cam_y_d = i_player_y;
    end
  end

  // Camera register, frozen between frame starts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cam_x_q <= '0;
      cam_y_q <= '0;
    end else begin
      cam_x_q <= cam_x_d;
      cam_y_q <= cam_y_d;
    end
  end

  map_coord_xlate #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .H_WIDTH    (H_WIDTH),
    .V_WIDTH    (V_WIDTH),
    .POS_WIDTH  (POS_WIDTH),
    .MAP_LOG2_W (MAP_LOG2_W),
    .MAP_LOG2_H (MAP_LOG2_H)
  ) u_xlate (
    .cam_x_i (cam_x_d),
    .cam_y_i (cam_y_d),
    .h_i     (i_VGA_H),
    .v_i     (i_VGA_V),
    .map_x_o (s1_mx_d),
    .map_y_o (s1_my_d),
    .oob_o   (s1_oob_d)
  );

  // Stage 1 register: translated coordinates and the busy flag of this slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_busy_q  <= 1'b0;
      s1_mx_q    <= '0;
      s1_my_q    <= '0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
    end else begin
      s1_valid_q <= i_req_valid;
      s1_oob_q   <= s1_oob_d;
      s1_busy_q  <= i_sram_busy;
      s1_mx_q    <= s1_mx_d;
      s1_my_q    <= s1_my_d;
      s1_h_q     <= i_VGA_H;
      s1_v_q     <= i_VGA_V;
    end
  end

  // Out-of-map wins over busy so off-map pixels never count as misses
  always_comb begin
    s2_kind_d = FETCH_READ;
    if (s1_oob_q) begin
      s2_kind_d = FETCH_OOB;
    end else if (s1_busy_q) begin
      s2_kind_d = FETCH_MISS;
    end
    rd_d   = s1_valid_q && (s2_kind_d == FETCH_READ);
    addr_d = rd_d ? ADDR_WIDTH'({s1_my_q, s1_mx_q}) : addr_q;
  end

  // Stage 2 register: SRAM request and slot classification
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_kind_q  <= FETCH_READ;
      s2_h_q     <= '0;
      s2_v_q     <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_kind_q  <= s2_kind_d;
      s2_h_q     <= s1_h_q;
      s2_v_q     <= s1_v_q;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
    end
  end

  assign sram_rgb = rgb565_to_rgb888(i_sram_data[15:0]);

  // Colour selection, last-good tracking and per-frame miss accounting
  always_comb begin
    pix_color_d  = pix_color_q;
    pix_h_d      = pix_h_q;
    pix_v_d      = pix_v_q;
    last_color_d = last_color_q;
    miss_now     = 1'b0;
    if (s2_valid_q) begin
      pix_h_d = s2_h_q;
      pix_v_d = s2_v_q;
      case (s2_kind_q)
        FETCH_READ: begin
          pix_color_d  = sram_rgb;
          last_color_d = sram_rgb;
        end
        FETCH_OOB: begin
          pix_color_d = BORDER_COLOR;
        end
        default: begin
          pix_color_d = last_color_q;
          miss_now    = 1'b1;
        end
      endcase
    end
    // A miss landing on the frame-start cycle belongs to the new frame
    frame_miss_d = frame_miss_q;
    if (frame_start) begin
      frame_miss_d = miss_acc_q;
      miss_acc_d   = miss_now ? MISS_WIDTH'(1) : '0;
    end else if (miss_now && (miss_acc_q != '1)) begin
      miss_acc_d   = miss_acc_q + MISS_WIDTH'(1);
    end else begin
      miss_acc_d   = miss_acc_q;
    end
  end

  // Stage 3 register: visible pixel and frame statistics
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_valid_q  <= 1'b0;
      pix_color_q  <= '0;
      pix_h_q      <= '0;
      pix_v_q      <= '0;
      last_color_q <= BORDER_COLOR;
      miss_acc_q   <= '0;
      frame_miss_q <= '0;
    end else begin
      pix_valid_q  <= s2_valid_q;
      pix_color_q  <= pix_color_d;
      pix_h_q      <= pix_h_d;
      pix_v_q      <= pix_v_d;
      last_color_q <= last_color_d;
      miss_acc_q   <= miss_acc_d;
      frame_miss_q <= frame_miss_d;
    end
  end

  assign o_sram_rd        = rd_q;
  assign o_sram_addr      = addr_q;
  assign o_pixel_valid    = pix_valid_q;
  assign o_pixel_color    = pix_color_q;
  assign o_pixel_H        = pix_h_q;
  assign o_pixel_V        = pix_v_q;
  assign o_frame_miss_cnt = frame_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_map_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_pixel_fetch
// Brief    : Scoreboard bench for map_pixel_fetch with a behavioural SRAM.
// Revision : 1.0
// ============================================================================
module tb_map_pixel_fetch;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [9:0]         vga_h = '0, vga_v = '0;
  logic               req_valid = 1'b0;
  logic signed [10:0] player_x = '0, player_y = '0;
  logic               sram_busy = 1'b0;
  logic [19:0]        sram_addr;
  logic               sram_rd;
  logic [15:0]        sram_data = 16'hDEAD;
  logic               pix_valid;
  logic [23:0]        pix_color;
  logic [9:0]         pix_h, pix_v;
  logic [15:0]        frame_miss;

  map_pixel_fetch dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_VGA_H          (vga_h),
    .i_VGA_V          (vga_v),
    .i_req_valid      (req_valid),
    .i_player_x       (player_x),
    .i_player_y       (player_y),
    .i_sram_busy      (sram_busy),
    .o_sram_addr      (sram_addr),
    .o_sram_rd        (sram_rd),
    .i_sram_data      (sram_data),
    .o_pixel_valid    (pix_valid),
    .o_pixel_color    (pix_color),
    .o_pixel_H        (pix_h),
    .o_pixel_V        (pix_v),
    .o_frame_miss_cnt (frame_miss)
  );

  always #5 clk = ~clk;

  // Map contents: two fixed words, a hash of the address elsewhere
  function automatic logic [15:0] sram_word(input logic [19:0] a);
    if (a == 20'h80200) return 16'hF800;
    if (a == 20'h80124) return 16'h07E0;
    return a[15:0] ^ {a[19:16], a[19:8]};
  endfunction

  // SRAM answers the read that is on the bus, ready before the next edge
  always @(negedge clk) sram_data = sram_rd ? sram_word(sram_addr) : 16'hDEAD;

  function automatic logic [23:0] expand(input logic [15:0] w);
    int r, g, b;
    r = (w >> 11) & 31;
    g = (w >> 5) & 63;
    b = w & 31;
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  typedef struct {
    logic        valid;
    logic [23:0] color;
    logic [9:0]  h, v;
    logic        rd;
    logic [19:0] addr;
    logic        miss;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0, n_errors = 0;
  int          m_cam_x = 0, m_cam_y = 0;
  logic [23:0] m_last = 24'h202020, m_hold = 24'h0;
  logic [15:0] m_acc = 0, m_fm = 0;
  logic        latch_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cam_x = 0; m_cam_y = 0;
    m_last = 24'h202020; m_hold = 24'h0;
    m_acc = 0; m_fm = 0;
    latch_pend = 1'b0;
  endtask

  // One clock slot: check what is due, then drive and predict the new slot
  task automatic step(input logic vld, input int h, input int v,
                      input int px, input int py, input logic busy);
    exp_t e, o;
    logic miss_now;
    int   wx, wy;
    logic oob;
    @(negedge clk);
    miss_now = 1'b0;
    if (exp_q.size() >= 3) begin
      o = exp_q.pop_front();
      check("pix_valid", 64'(pix_valid), 64'(o.valid));
      check("pix_color", 64'(pix_color), 64'(o.color));
      if (o.valid) begin
        check("pix_H", 64'(pix_h), 64'(o.h));
        check("pix_V", 64'(pix_v), 64'(o.v));
      end
      miss_now = o.miss;
    end
    if (latch_pend) begin
      m_fm  = m_acc;
      m_acc = miss_now ? 16'd1 : 16'd0;
    end else if (miss_now && m_acc != 16'hFFFF) begin
      m_acc = m_acc + 16'd1;
    end
    check("frame_miss", 64'(frame_miss), 64'(m_fm));
    if (exp_q.size() >= 2) begin
      check("sram_rd", 64'(sram_rd), 64'(exp_q[0].rd));
      if (exp_q[0].rd) check("sram_addr", 64'(sram_addr), 64'(exp_q[0].addr));
    end

    req_valid = vld; vga_h = 10'(h); vga_v = 10'(v);
    player_x = 11'(px); player_y = 11'(py); sram_busy = busy;

    latch_pend = vld && h == 0 && v == 0;
    if (latch_pend) begin m_cam_x = px; m_cam_y = py; end
    wx  = m_cam_x - 320 + h;
    wy  = m_cam_y - 240 + v;
    oob = (wx < 0) || (wx > 1023) || (wy < 0) || (wy > 1023);
    e.valid = vld; e.h = 10'(h); e.v = 10'(v); e.miss = 1'b0;
    e.rd    = vld && !oob && !busy;
    e.addr  = oob ? 20'h0 : 20'(wy * 1024 + wx);
    if (!vld)      e.color = m_hold;
    else if (oob)  e.color = 24'h202020;
    else if (busy) begin e.color = m_last; e.miss = 1'b1; end
    else begin     e.color = expand(sram_word(e.addr)); m_last = e.color; end
    m_hold = e.color;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    64'(sram_rd),    64'd0);
    check({tag, "_addr"},  64'(sram_addr),  64'd0);
    check({tag, "_valid"}, 64'(pix_valid),  64'd0);
    check({tag, "_color"}, 64'(pix_color),  64'd0);
    check({tag, "_H"},     64'(pix_h),      64'd0);
    check({tag, "_V"},     64'(pix_v),      64'd0);
    check({tag, "_miss"},  64'(frame_miss), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Frame A: camera at origin, everything near the top-left is off-map
    step(1, 0, 0, 0, 0, 0);        // wx = -320, border
    step(1, 1, 0, 0, 0, 1);        // off-map while busy: not a miss
    step(0, 5, 0, 0, 0, 0);        // invalid slot, colour held

    // Frame B: camera centred on the map
    step(1, 0, 0, 512, 512, 0);    // frame A had no misses
    step(1, 320, 240, 512, 512, 0);// addr 80200 -> FF0000
    step(0, 0, 0, 512, 512, 0);
    step(1, 100, 240, 512, 512, 0);// 07E0 -> 00FF00
    for (int i = 101; i <= 105; i++) step(1, i, 240, 512, 512, 1);
    step(1, 200, 240, 600, 512, 0);// player moved, camera not yet
    step(1, 201, 241, 600, 512, 0);

    // Frame C: new camera applies at (0,0), misses of frame B reported
    step(1, 0, 0, 600, 512, 0);    // wx = 280
    step(1, 10, 10, 600, 512, 0);
    step(0, 0, 0, 600, 512, 0);
    step(0, 0, 0, 600, 512, 0);
    step(0, 0, 0, 600, 512, 0);

    // Right edge: 1151 off-map, then 1023 in range
    step(1, 0, 0, 832, 512, 0);
    step(1, 639, 0, 832, 512, 0);
    step(1, 0, 0, 704, 512, 0);
    step(1, 639, 0, 704, 512, 0);
    step(1, 639, 1, 704, 512, 1);  // miss on in-range pixel
    // Left edge: -1 off-map, 0 in range; miss on the frame-start cycle slot
    step(1, 0, 0, 319, 512, 0);
    step(1, 1, 0, 319, 512, 0);
    step(1, 2, 0, 319, 512, 0);

    // Random traffic inside one frame
    step(1, 0, 0, 700, 600, 0);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 5) != 0, $urandom_range(1, 639), $urandom_range(0, 479),
           700, 600, $urandom_range(0, 3) == 0);
    step(1, 0, 0, 700, 600, 0);
    step(1, 5, 5, 700, 600, 0);
    step(0, 0, 0, 700, 600, 0);
    step(0, 0, 0, 700, 600, 0);
    step(0, 0, 0, 700, 600, 0);
    step(0, 0, 0, 700, 600, 0);

    // Reset shortly after a read goes out
    step(1, 300, 200, 512, 512, 0);
    step(0, 0, 0, 512, 512, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 400, 300, 123, 77, 0); // camera stays 0 until next (0,0)
    step(0, 0, 0, 123, 77, 0);
    step(0, 0, 0, 123, 77, 0);
    step(0, 0, 0, 123, 77, 0);
    step(0, 0, 0, 123, 77, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
